// File: rtl/vga_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// vga_pattern_ctrl
//
// Timing and test-pattern controller for a 640x480@60Hz VGA output running on
// the 25 MHz pixel clock. Two free-running counters walk each line and each
// frame through sync, back porch, active and front porch. A small pattern
// state machine steps through a set of RGB565 test patterns. It changes
// pattern only on frame boundaries.
//
// Every output is registered from the decode of the current counter values.
// This gives a fixed one-clock latency, and all outputs stay mutually aligned.
//
// Optional build macro:
//   VGA_TEST_BORDER_EN - when defined, the first/last active column and the
//                        first/last active line are forced to white (FFFF).
//                        When undefined, no border logic is built.
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   rst_n        in   asynchronous active-low reset
//   pause        in   level; freezes auto-advance (frame counter holds)
//   next_req     in   one-cycle pulse; advance at the next frame boundary
//   hys          out  horizontal sync, active low
//   vys          out  vertical sync, active low
//   de           out  data enable, high in the active pixel area
//   lcd_rgb      out  RGB565 pixel, zero outside the active area
//   frame_start  out  one-cycle pulse on the first output cycle of a frame
//   pat_idx      out  index of the pattern currently shown
// ---------------------------------------------------------------------------
module vga_pattern_ctrl #(
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int H_ACT          = 640,
    parameter int H_FRONT        = 16,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int V_ACT          = 480,
    parameter int V_FRONT        = 10,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        next_req,
    output logic        hys,
    output logic        vys,
    output logic        de,
    output logic [15:0] lcd_rgb,
    output logic        frame_start,
    output logic [2:0]  pat_idx
);

    localparam int H_TOT     = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOT     = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int H_ACT_BEG = H_SYNC + H_BACK;
    localparam int H_ACT_END = H_SYNC + H_BACK + H_ACT;
    localparam int V_ACT_BEG = V_SYNC + V_BACK;
    localparam int V_ACT_END = V_SYNC + V_BACK + V_ACT;
    localparam int BAR_W     = H_ACT / 8;

    localparam int HW = $clog2(H_TOT);
    localparam int VW = $clog2(V_TOT);
    localparam int FW = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        PAT_RED   = 3'd0,
        PAT_GREEN = 3'd1,
        PAT_BLUE  = 3'd2,
        PAT_WHITE = 3'd3,
        PAT_BARS  = 3'd4
    } pat_e;

    // Counter and control state
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          pend_q, pend_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    pat_e          pat_q, pat_d;

    // Registered outputs
    logic          hys_q, hys_d;
    logic          vys_q, vys_d;
    logic          de_q, de_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          fs_q, fs_d;
    logic [2:0]    pat_idx_q, pat_idx_d;

    // Decode helpers
    logic          h_end;
    logic          frame_end;
    logic          advance;
    logic          h_active;
    logic          v_active;
    logic [15:0]   pat_colour;

    assign h_end     = (hcnt_q == HW'(H_TOT - 1));
    assign frame_end = h_end && (vcnt_q == VW'(V_TOT - 1));
    assign h_active  = (hcnt_q >= HW'(H_ACT_BEG)) && (hcnt_q < HW'(H_ACT_END));
    assign v_active  = (vcnt_q >= VW'(V_ACT_BEG)) && (vcnt_q < VW'(V_ACT_END));

    // A pending request always wins. Otherwise the counter must reach its
    // last value while not paused.
    assign advance = pend_q || (!pause && (fcnt_q == FW'(FRAMES_PER_PAT - 1)));

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Line and frame position counters
    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (h_end) begin
            hcnt_d = '0;
            if (vcnt_q == VW'(V_TOT - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end
    end

    // The bar counter tracks the current column within the active area.
    // It is preloaded on the cycle before h-active begins, so the active
    // area needs no divider. The index may wrap past 7 at the end of the
    // line; that value is never used because it lies outside h-active.
    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (hcnt_q == HW'(H_ACT_BEG - 1)) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (h_active) begin
            if (bar_pix_q == BW'(BAR_W - 1)) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + BW'(1);
            end
        end
    end

    // Frame counter and pending request are updated only on the last cycle
    // of a frame. The exception is next_req, which is latched in any cycle.
    // A request that arrives on the boundary cycle itself survives the
    // clear, so it takes effect at the following boundary.
    always_comb begin
        fcnt_d = fcnt_q;
        pend_d = pend_q | next_req;
        if (frame_end) begin
            if (advance) begin
                fcnt_d = '0;
                pend_d = next_req;
            end else if (!pause) begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Pattern state machine: next-state logic
    always_comb begin
        pat_d = pat_q;
        if (frame_end && advance) begin
            case (pat_q)
                PAT_RED:   pat_d = PAT_GREEN;
                PAT_GREEN: pat_d = PAT_BLUE;
                PAT_BLUE:  pat_d = PAT_WHITE;
                PAT_WHITE: pat_d = PAT_BARS;
                default:   pat_d = PAT_RED;
            endcase
        end
    end

    // Pattern colour for the current pixel, before gating by de
    always_comb begin
        pat_colour = 16'h0000;
        case (pat_q)
            PAT_RED:   pat_colour = 16'hF800;
            PAT_GREEN: pat_colour = 16'h07E0;
            PAT_BLUE:  pat_colour = 16'h001F;
            PAT_WHITE: pat_colour = 16'hFFFF;
            PAT_BARS:  pat_colour = bar_colour(bar_idx_q);
            default:   pat_colour = 16'h0000;
        endcase
`ifdef VGA_TEST_BORDER_EN
        if ((hcnt_q == HW'(H_ACT_BEG)) || (hcnt_q == HW'(H_ACT_END - 1)) ||
            (vcnt_q == VW'(V_ACT_BEG)) || (vcnt_q == VW'(V_ACT_END - 1))) begin
            pat_colour = 16'hFFFF;
        end
`endif
    end

    // Output decode from the current counters. These values are registered,
    // so the connector sees them one clock later, all outputs together.
    // pat_idx is sampled from the pattern state here, which makes the new
    // index first appear in the same cycle as frame_start.
    always_comb begin
        hys_d     = !(hcnt_q < HW'(H_SYNC));
        vys_d     = !(vcnt_q < VW'(V_SYNC));
        de_d      = h_active && v_active;
        rgb_d     = (h_active && v_active) ? pat_colour : 16'h0000;
        fs_d      = (hcnt_q == '0) && (vcnt_q == '0);
        pat_idx_d = pat_q;
    end

    // Counter, control and pattern state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            fcnt_q    <= '0;
            pend_q    <= 1'b0;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= PAT_RED;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            fcnt_q    <= fcnt_d;
            pend_q    <= pend_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hys_q     <= 1'b1;
            vys_q     <= 1'b1;
            de_q      <= 1'b0;
            rgb_q     <= 16'h0000;
            fs_q      <= 1'b0;
            pat_idx_q <= 3'd0;
        end else begin
            hys_q     <= hys_d;
            vys_q     <= vys_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
            pat_idx_q <= pat_idx_d;
        end
    end

    assign hys         = hys_q;
    assign vys         = vys_q;
    assign de          = de_q;
    assign lcd_rgb     = rgb_q;
    assign frame_start = fs_q;
    assign pat_idx     = pat_idx_q;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_ctrl
//
// Self-checking bench for vga_pattern_ctrl. It shrinks the timing so that
// many frames fit in a short run. A reference model tracks the absolute
// pixel position since reset and the pattern schedule. It checks every
// output on every cycle.
// ---------------------------------------------------------------------------
module tb_vga_pattern_ctrl;

    localparam int HS = 4, HB = 3, HA = 16, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;
    localparam int FPP   = 3;
    localparam int HT    = HS + HB + HA + HF;
    localparam int VT    = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause = 1'b0;
    logic        next_req = 1'b0;
    logic        hys, vys, de, frame_start;
    logic [15:0] lcd_rgb;
    logic [2:0]  pat_idx;

    int errors = 0;
    int checks = 0;

    // Reference model state: ticks since reset, pattern, frame count, request
    int mT, mPat, mFcnt;
    bit mPend;

    vga_pattern_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
        .FRAMES_PER_PAT(FPP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .next_req(next_req),
        .hys(hys), .vys(vys), .de(de), .lcd_rgb(lcd_rgb),
        .frame_start(frame_start), .pat_idx(pat_idx)
    );

    always #5 clk = ~clk;

    // Compares one observed value against its expected value and records
    // a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] refColour(input int pat, input int x, input int y);
        logic [15:0] c;
`ifdef VGA_TEST_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 16'hFFFF;
`endif
        case (pat)
            0: c = 16'hF800;
            1: c = 16'h07E0;
            2: c = 16'h001F;
            3: c = 16'hFFFF;
            default: begin
                case (x / (HA / 8))
                    0: c = 16'hFFFF;
                    1: c = 16'hFFE0;
                    2: c = 16'h07FF;
                    3: c = 16'h07E0;
                    4: c = 16'hF81F;
                    5: c = 16'hF800;
                    6: c = 16'h001F;
                    default: c = 16'h0000;
                endcase
            end
        endcase
        return c;
    endfunction

    function automatic logic [31:0] outVec();
        return {9'd0, hys, vys, de, frame_start, pat_idx, lcd_rgb};
    endfunction

    task automatic resetModel();
        mT = 0; mPat = 0; mFcnt = 0; mPend = 1'b0;
    endtask

    // Lets one clock edge pass with the inputs already applied, then checks
    // the outputs against the model. The model then absorbs that edge, and
    // any next_req pulse is dropped.
    task automatic applyStimulus();
        int pos, h, v;
        bit act;
        logic [31:0] exp;
        @(negedge clk);
        pos = mT % FRAME;
        h   = pos % HT;
        v   = pos / HT;
        act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        exp = {9'd0, (h >= HS), (v >= VS), act, (pos == 0), 3'(mPat),
               act ? refColour(mPat, h - HS - HB, v - VS - VB) : 16'h0000};
        checkOutput("outs", outVec(), exp);
        if (pos == FRAME - 1) begin
            if (mPend || (!pause && mFcnt == FPP - 1)) begin
                mPat  = (mPat + 1) % 5;
                mFcnt = 0;
                mPend = 1'b0;
            end else if (!pause) begin
                mFcnt++;
            end
        end
        if (next_req) mPend = 1'b1;
        mT++;
        next_req = 1'b0;
    endtask

    task automatic runFrames(input int n);
        repeat (n * FRAME) applyStimulus();
    endtask

    // Steps until the next edge will process the given frame position
    task automatic runTo(input int target);
        for (int i = 0; i < FRAME && (mT % FRAME) != target; i++) applyStimulus();
    endtask

    initial begin
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_vals", outVec(), {9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
        rst_n = 1'b1;

        // Free-running rotation through every pattern and back to RED
        runFrames(16);

        // Several requests inside one frame give exactly one advance
        runTo(FRAME / 3);
        for (int k = 0; k < 3; k++) begin
            next_req = 1'b1;
            applyStimulus();
            repeat (5) applyStimulus();
        end
        runFrames(2);

        // Pause holds the pattern, and a request still advances it
        pause = 1'b1;
        runFrames(8);
        next_req = 1'b1;
        applyStimulus();
        runFrames(2);
        pause = 1'b0;

        // A request on the boundary cycle takes effect one frame later
        runTo(FRAME - 1);
        next_req = 1'b1;
        applyStimulus();
        runFrames(3);

        // Random pause levels and request pulses
        repeat (20 * FRAME) begin
            if ($urandom_range(0, 199) == 0) next_req = 1'b1;
            if ($urandom_range(0, 499) == 0) pause = ~pause;
            applyStimulus();
        end
        pause = 1'b0;

        // Asynchronous reset in the middle of an active line
        runTo((VS + VB + 1) * HT + HS + HB + 5);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", outVec(), {9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_hold", outVec(), {9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        runFrames(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
